issue_queue: RTL

ISSUE_QUEUE -- requirements
Module: issue_queue

---
 rtl/issue_queue.sv | 77 +++++++
 1 files changed

// File: rtl/issue_queue.sv
// Circular-buffer issue queue between decode and dispatch: show-ahead head, 1-cycle write-to-read latency, writes refused when full.
// Define ISSUE_Q_BYPASS_EN to forward a write straight to the head port while the queue is empty.
module issue_queue #(
    parameter int ISSUE_Q_WIDTH = 123,
    parameter int ISSUE_Q_DEPTH = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             issue_q_wen,
    input  logic [ISSUE_Q_WIDTH-1:0]         issue_q_wdata,
    output logic                             issue_q_wok,
    input  logic                             issue_q_ren,
    output logic [ISSUE_Q_WIDTH-1:0]         issue_q_rdata,
    output logic                             issue_q_rok,
    output logic [$clog2(ISSUE_Q_DEPTH):0]   issue_q_count
);

    localparam int AW = $clog2(ISSUE_Q_DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [ISSUE_Q_WIDTH-1:0] r_mem [ISSUE_Q_DEPTH];
    logic [PW-1:0]            r_wptr;
    logic [PW-1:0]            r_rptr;

    logic          w_empty;
    logic          w_full;
    logic          w_wr;
    logic          w_rd;
    logic [AW-1:0] w_widx;
    logic [AW-1:0] w_ridx;

    assign w_widx  = r_wptr[AW-1:0];
    assign w_ridx  = r_rptr[AW-1:0];
    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (w_widx == w_ridx) && (r_wptr[AW] != r_rptr[AW]);

    // Full is judged on registered pointers only, so a same-cycle pop never frees a slot.
    assign issue_q_wok   = ~w_full;
    assign issue_q_count = r_wptr - r_rptr;

`ifdef ISSUE_Q_BYPASS_EN
    logic w_bypass;

    assign w_bypass      = w_empty & issue_q_wen & ~flush;
    assign issue_q_rok   = ~w_empty | w_bypass;
    assign issue_q_rdata = w_empty ? issue_q_wdata : r_mem[w_ridx];
    // A bypassed packet popped in the same cycle never touches storage or pointers.
    assign w_wr = issue_q_wen & issue_q_wok & ~flush & ~(w_bypass & issue_q_ren);
    assign w_rd = issue_q_ren & ~w_empty & ~flush;
`else
    assign issue_q_rok   = ~w_empty;
    assign issue_q_rdata = r_mem[w_ridx];
    assign w_wr = issue_q_wen & issue_q_wok & ~flush;
    assign w_rd = issue_q_ren & issue_q_rok & ~flush;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (flush) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + PTR_ONE;
            if (w_rd) r_rptr <= r_rptr + PTR_ONE;
        end
    end

    // Entry storage is deliberately left out of reset and flush; only pointers define validity.
    always_ff @(posedge clk) begin
        if (w_wr) r_mem[w_widx] <= issue_q_wdata;
    end

endmodule
